dram_ddr_rptr_pipe: RTL and testbench
=====================================

DRAM_DDR_RPTR_PIPE -- requirements
Module: dram_ddr_rptr_pipe

Interface
REQ-001 Parameter NSTG, default 2, number of register stages per direction; legal range 1..4.
REQ-002 Parameter ADDR_W, default 15, DRAM address width.
REQ-003 Parameters BANK_W 3, CS_W 4, WR_W 288, RD_W 256, ECC_W 32, PCI_W 5: bank, chip-select, write-data, read-data, read-ECC and pointer-clock-invert widths.
REQ-004 One clock and a synchronous, active-low reset: ports clk and rst_l.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_l  in  1  synchronous active-low reset.
REQ-007 dram_io_* command inputs, all in: cas_l, ras_l, write_en_l, cke, clk_enable, pad_enable, pad_clk_inv, drive_data, drive_enable (1 each); addr ADDR_W; bank BANK_W; cs_l CS_W; ptr_clk_inv PCI_W; data_out WR_W.
REQ-008 dram_io_channel_disabled  in  1  forces the command path to idle.
REQ-009 Each dram_io_* input has a matching *_buf output of equal width, carrying the delayed value.
REQ-010 io_dram_data_valid in 1; io_dram_data_in in RD_W; io_dram_ecc_in in ECC_W: read-return beat.
REQ-011 io_dram_data_valid_buf out 1; io_dram_data_in_buf out RD_W; io_dram_ecc_in_buf out ECC_W.
REQ-012 cmd_inflight  out  clog2(NSTG+1)  number of command-path stages holding an active command.
REQ-013 rd_inflight  out  clog2(NSTG+1)  number of read-path stages holding a valid beat.

Function
REQ-014 Every *_buf output is its input delayed exactly NSTG cycles, except where REQ-015..REQ-019 say otherwise.
REQ-015 An active command is any cs_l bit low at stage-0 input, after disable masking.
REQ-016 When channel_disabled is 1 at stage-0 input, the entry written that cycle is idle: cs_l all ones, ras_l/cas_l/write_en_l 1, drive_data 0, drive_enable 0; addr/bank hold the previous stage-0 value.
REQ-017 A command presented in the same cycle channel_disabled rises is suppressed; commands already in flight drain unmodified.
REQ-018 dram_io_data_out stage registers load only when drive_data is 1 at that stage; otherwise they hold, so idle cycles cause no toggling.
REQ-019 Read data/ECC stage registers load only when the valid bit entering that stage is 1; otherwise they hold; valid itself always shifts.
REQ-020 cmd_inflight/rd_inflight are registered population counts of the stage active/valid bits, updated every cycle; range 0..NSTG with no wrap.
REQ-021 Back-to-back valid beats on every cycle shall all emerge in order with no gaps or loss (rd_inflight = NSTG in steady state).
REQ-022 No backpressure exists; the block never stalls or drops an input.

Reset
REQ-023 While rst_l is 0 at a clock edge, all stages shall clear the same cycle: cs_l_buf all ones; ras_l/cas_l/write_en_l_buf 1; channel_disabled_buf 1; all other 1-bit outputs 0; addr, bank, data, ECC, ptr_clk_inv 0; both counters 0.
REQ-024 Reset mid-operation discards all in-flight commands and beats; nothing emerges after rst_l rises that was captured before it.
REQ-025 After rst_l rises, the first input sample appears at the outputs NSTG cycles later.

Structure
REQ-026 Package dram_rptr_pkg shall hold default width constants, idle command constants (CS_IDLE, RAS/CAS/WE idle 1), and the NSTG legal-range check.
REQ-027 One sub-module, dram_rptr_stage (parametrised width, load enable, reset value), shall be instantiated per stage per field group.

Verification
REQ-028 NSTG=2: single command cs_l=4'b1110, addr=0x1A5 at cycle 0 -> appears at outputs on cycle 2; cmd_inflight reads 1 on cycles 1 and 2, then 0.
REQ-029 channel_disabled=1 in the same cycle as a command with cs_l=4'b0111 -> cs_l_buf stays 4'b1111 and ras/cas/we_buf stay 1 for all following cycles.
REQ-030 Valid beats on 8 consecutive cycles, data=0..7 -> data_in_buf=0..7 in order, valid_buf high for 8 cycles, rd_inflight=NSTG during the burst.
REQ-031 Beat 0xAA with valid, then valid=0 with data=0x55 -> data_in_buf holds 0xAA and never shows 0x55.
REQ-032 rst_l low for one cycle while 2 commands and 2 beats are in flight -> all outputs equal REQ-023 values on the next cycle and no old beat emerges.
REQ-033 Repeat REQ-028 with NSTG=1 and NSTG=4 -> latency of 1 and 4 cycles respectively.

Source files
------------

// File: rtl/dram_rptr_pkg.sv
// Shared constants, idle command encoding and stage-count check for the DRAM pointer pipe.
package dram_rptr_pkg;

  localparam int unsigned DEF_NSTG   = 2;
  localparam int unsigned DEF_ADDR_W = 15;
  localparam int unsigned DEF_BANK_W = 3;
  localparam int unsigned DEF_CS_W   = 4;
  localparam int unsigned DEF_WR_W   = 288;
  localparam int unsigned DEF_RD_W   = 256;
  localparam int unsigned DEF_ECC_W  = 32;
  localparam int unsigned DEF_PCI_W  = 5;

  localparam int unsigned NSTG_MIN = 1;
  localparam int unsigned NSTG_MAX = 4;

  // Idle command: no chip selected, all strobes deasserted (active-low high).
  localparam logic [DEF_CS_W-1:0] CS_IDLE  = '1;
  localparam logic                RAS_IDLE = 1'b1;
  localparam logic                CAS_IDLE = 1'b1;
  localparam logic                WE_IDLE  = 1'b1;

  // Single-bit command strobes that travel together with cs_l.
  typedef struct packed {
    logic ras_l;
    logic cas_l;
    logic we_l;
    logic drive_data;
    logic drive_enable;
  } cmd_ctl_t;

  localparam cmd_ctl_t CMD_CTL_IDLE = '{
    ras_l:        RAS_IDLE,
    cas_l:        CAS_IDLE,
    we_l:         WE_IDLE,
    drive_data:   1'b0,
    drive_enable: 1'b0
  };

  // True when the requested stage count is supported.
  function automatic logic nstg_legal(input int unsigned n);
    return (n >= NSTG_MIN) && (n <= NSTG_MAX);
  endfunction

endpackage

// File: rtl/dram_ddr_rptr_pipe_if.sv
// Command, write-data and read-return bundle of the DRAM pointer pipe.
interface dram_ddr_rptr_pipe_if
  import dram_rptr_pkg::*;
#(
  parameter int unsigned NSTG   = DEF_NSTG,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned BANK_W = DEF_BANK_W,
  parameter int unsigned CS_W   = DEF_CS_W,
  parameter int unsigned WR_W   = DEF_WR_W,
  parameter int unsigned RD_W   = DEF_RD_W,
  parameter int unsigned ECC_W  = DEF_ECC_W,
  parameter int unsigned PCI_W  = DEF_PCI_W
);
  localparam int unsigned CNT_W = $clog2(NSTG + 1);

  logic              dram_io_cas_l,       dram_io_cas_l_buf;
  logic              dram_io_ras_l,       dram_io_ras_l_buf;
  logic              dram_io_write_en_l,  dram_io_write_en_l_buf;
  logic              dram_io_cke,         dram_io_cke_buf;
  logic              dram_io_clk_enable,  dram_io_clk_enable_buf;
  logic              dram_io_pad_enable,  dram_io_pad_enable_buf;
  logic              dram_io_pad_clk_inv, dram_io_pad_clk_inv_buf;
  logic              dram_io_drive_data,  dram_io_drive_data_buf;
  logic              dram_io_drive_enable, dram_io_drive_enable_buf;
  logic              dram_io_channel_disabled, dram_io_channel_disabled_buf;
  logic [ADDR_W-1:0] dram_io_addr,        dram_io_addr_buf;
  logic [BANK_W-1:0] dram_io_bank,        dram_io_bank_buf;
  logic [CS_W-1:0]   dram_io_cs_l,        dram_io_cs_l_buf;
  logic [PCI_W-1:0]  dram_io_ptr_clk_inv, dram_io_ptr_clk_inv_buf;
  logic [WR_W-1:0]   dram_io_data_out,    dram_io_data_out_buf;
  logic              io_dram_data_valid,  io_dram_data_valid_buf;
  logic [RD_W-1:0]   io_dram_data_in,     io_dram_data_in_buf;
  logic [ECC_W-1:0]  io_dram_ecc_in,      io_dram_ecc_in_buf;
  logic [CNT_W-1:0]  cmd_inflight;
  logic [CNT_W-1:0]  rd_inflight;

  modport master (
    output dram_io_cas_l, dram_io_ras_l, dram_io_write_en_l, dram_io_cke,
           dram_io_clk_enable, dram_io_pad_enable, dram_io_pad_clk_inv,
           dram_io_drive_data, dram_io_drive_enable, dram_io_channel_disabled,
           dram_io_addr, dram_io_bank, dram_io_cs_l, dram_io_ptr_clk_inv,
           dram_io_data_out, io_dram_data_valid, io_dram_data_in, io_dram_ecc_in,
    input  dram_io_cas_l_buf, dram_io_ras_l_buf, dram_io_write_en_l_buf, dram_io_cke_buf,
           dram_io_clk_enable_buf, dram_io_pad_enable_buf, dram_io_pad_clk_inv_buf,
           dram_io_drive_data_buf, dram_io_drive_enable_buf, dram_io_channel_disabled_buf,
           dram_io_addr_buf, dram_io_bank_buf, dram_io_cs_l_buf, dram_io_ptr_clk_inv_buf,
           dram_io_data_out_buf, io_dram_data_valid_buf, io_dram_data_in_buf,
           io_dram_ecc_in_buf, cmd_inflight, rd_inflight
  );

  modport slave (
    input  dram_io_cas_l, dram_io_ras_l, dram_io_write_en_l, dram_io_cke,
           dram_io_clk_enable, dram_io_pad_enable, dram_io_pad_clk_inv,
           dram_io_drive_data, dram_io_drive_enable, dram_io_channel_disabled,
           dram_io_addr, dram_io_bank, dram_io_cs_l, dram_io_ptr_clk_inv,
           dram_io_data_out, io_dram_data_valid, io_dram_data_in, io_dram_ecc_in,
    output dram_io_cas_l_buf, dram_io_ras_l_buf, dram_io_write_en_l_buf, dram_io_cke_buf,
           dram_io_clk_enable_buf, dram_io_pad_enable_buf, dram_io_pad_clk_inv_buf,
           dram_io_drive_data_buf, dram_io_drive_enable_buf, dram_io_channel_disabled_buf,
           dram_io_addr_buf, dram_io_bank_buf, dram_io_cs_l_buf, dram_io_ptr_clk_inv_buf,
           dram_io_data_out_buf, io_dram_data_valid_buf, io_dram_data_in_buf,
           io_dram_ecc_in_buf, cmd_inflight, rd_inflight
  );

endinterface

// File: rtl/dram_rptr_stage.sv
// One pipeline register for a field group, with load enable and configurable reset value.
module dram_rptr_stage #(
  parameter int unsigned     W       = 1,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Reset wins over load; a deasserted enable holds the register.
  always_ff @(posedge clk) begin
    if (!rst_l)    r_q <= RST_VAL;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/dram_ddr_rptr_pipe.sv
// NSTG-deep retiming pipe for DRAM command/write-data and read-return paths.
module dram_ddr_rptr_pipe
  import dram_rptr_pkg::*;
#(
  parameter int unsigned NSTG   = DEF_NSTG,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned BANK_W = DEF_BANK_W,
  parameter int unsigned CS_W   = DEF_CS_W,
  parameter int unsigned WR_W   = DEF_WR_W,
  parameter int unsigned RD_W   = DEF_RD_W,
  parameter int unsigned ECC_W  = DEF_ECC_W,
  parameter int unsigned PCI_W  = DEF_PCI_W
) (
  input  logic                 clk,
  input  logic                 rst_l,
  dram_ddr_rptr_pipe_if.slave  bus
);

  localparam int unsigned CNT_W  = $clog2(NSTG + 1);
  localparam int unsigned CTL_W  = $bits(cmd_ctl_t);
  localparam int unsigned CMD_W  = CS_W + CTL_W;
  localparam int unsigned AB_W   = ADDR_W + BANK_W;
  localparam int unsigned MISC_W = 5 + PCI_W;
  localparam int unsigned RDE_W  = RD_W + ECC_W;
  localparam int unsigned DD_BIT = 1;  // drive_data position inside cmd_ctl_t

  localparam logic [CMD_W-1:0]  CMD_RST  = {{CS_W{CS_IDLE[0]}}, CMD_CTL_IDLE};
  localparam logic [MISC_W-1:0] MISC_RST = {4'b0000, 1'b1, {PCI_W{1'b0}}};

  if (!nstg_legal(NSTG)) begin : g_bad_nstg
    $fatal(1, "dram_ddr_rptr_pipe: NSTG must be within 1..4");
  end

  cmd_ctl_t           w_ctl_in;
  logic [CS_W-1:0]    w_cs_in;
  logic [CMD_W-1:0]   w_cmd_d  [NSTG];
  logic [CMD_W-1:0]   w_cmd_q  [NSTG];
  logic [AB_W-1:0]    w_ab_d   [NSTG];
  logic [AB_W-1:0]    w_ab_q   [NSTG];
  logic               w_ab_en  [NSTG];
  logic [MISC_W-1:0]  w_misc_d [NSTG];
  logic [MISC_W-1:0]  w_misc_q [NSTG];
  logic [WR_W-1:0]    w_wd_d   [NSTG];
  logic [WR_W-1:0]    w_wd_q   [NSTG];
  logic               w_vld_d  [NSTG];
  logic               w_vld_q  [NSTG];
  logic [RDE_W-1:0]   w_rde_d  [NSTG];
  logic [RDE_W-1:0]   w_rde_q  [NSTG];
  logic [CNT_W-1:0]   w_cmd_cnt;
  logic [CNT_W-1:0]   w_rd_cnt;
  logic [CNT_W-1:0]   r_cmd_cnt;
  logic [CNT_W-1:0]   r_rd_cnt;

  // A disabled channel turns the entry entering stage 0 into an idle command.
  always_comb begin
    w_ctl_in = CMD_CTL_IDLE;
    w_cs_in  = {CS_W{CS_IDLE[0]}};
    if (!bus.dram_io_channel_disabled) begin
      w_ctl_in.ras_l        = bus.dram_io_ras_l;
      w_ctl_in.cas_l        = bus.dram_io_cas_l;
      w_ctl_in.we_l         = bus.dram_io_write_en_l;
      w_ctl_in.drive_data   = bus.dram_io_drive_data;
      w_ctl_in.drive_enable = bus.dram_io_drive_enable;
      w_cs_in               = bus.dram_io_cs_l;
    end
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    if (k == 0) begin : g_head
      assign w_cmd_d[k]  = {w_cs_in, w_ctl_in};
      assign w_ab_d[k]   = {bus.dram_io_addr, bus.dram_io_bank};
      assign w_ab_en[k]  = ~bus.dram_io_channel_disabled;
      assign w_misc_d[k] = {bus.dram_io_cke, bus.dram_io_clk_enable, bus.dram_io_pad_enable,
                            bus.dram_io_pad_clk_inv, bus.dram_io_channel_disabled,
                            bus.dram_io_ptr_clk_inv};
      assign w_wd_d[k]   = bus.dram_io_data_out;
      assign w_vld_d[k]  = bus.io_dram_data_valid;
      assign w_rde_d[k]  = {bus.io_dram_data_in, bus.io_dram_ecc_in};
    end else begin : g_tail
      assign w_cmd_d[k]  = w_cmd_q[k-1];
      assign w_ab_d[k]   = w_ab_q[k-1];
      assign w_ab_en[k]  = 1'b1;
      assign w_misc_d[k] = w_misc_q[k-1];
      assign w_wd_d[k]   = w_wd_q[k-1];
      assign w_vld_d[k]  = w_vld_q[k-1];
      assign w_rde_d[k]  = w_rde_q[k-1];
    end

    dram_rptr_stage #(.W(CMD_W), .RST_VAL(CMD_RST)) u_cmd (
      .clk(clk), .rst_l(rst_l), .i_en(1'b1), .i_d(w_cmd_d[k]), .o_q(w_cmd_q[k]));
    dram_rptr_stage #(.W(AB_W), .RST_VAL('0)) u_ab (
      .clk(clk), .rst_l(rst_l), .i_en(w_ab_en[k]), .i_d(w_ab_d[k]), .o_q(w_ab_q[k]));
    dram_rptr_stage #(.W(MISC_W), .RST_VAL(MISC_RST)) u_misc (
      .clk(clk), .rst_l(rst_l), .i_en(1'b1), .i_d(w_misc_d[k]), .o_q(w_misc_q[k]));
    dram_rptr_stage #(.W(WR_W), .RST_VAL('0)) u_wd (
      .clk(clk), .rst_l(rst_l), .i_en(w_cmd_d[k][DD_BIT]), .i_d(w_wd_d[k]), .o_q(w_wd_q[k]));
    dram_rptr_stage #(.W(1), .RST_VAL(1'b0)) u_vld (
      .clk(clk), .rst_l(rst_l), .i_en(1'b1), .i_d(w_vld_d[k]), .o_q(w_vld_q[k]));
    dram_rptr_stage #(.W(RDE_W), .RST_VAL('0)) u_rde (
      .clk(clk), .rst_l(rst_l), .i_en(w_vld_d[k]), .i_d(w_rde_d[k]), .o_q(w_rde_q[k]));
  end

  // Population of the values being loaded, so the registered count matches stage contents.
  always_comb begin
    w_cmd_cnt = '0;
    w_rd_cnt  = '0;
    for (int k = 0; k < NSTG; k++) begin
      w_cmd_cnt = w_cmd_cnt + CNT_W'(~&w_cmd_d[k][CMD_W-1:CTL_W]);
      w_rd_cnt  = w_rd_cnt + CNT_W'(w_vld_d[k]);
    end
  end

  // In-flight counters.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_cmd_cnt <= '0;
      r_rd_cnt  <= '0;
    end else begin
      r_cmd_cnt <= w_cmd_cnt;
      r_rd_cnt  <= w_rd_cnt;
    end
  end

  assign {bus.dram_io_cs_l_buf, bus.dram_io_ras_l_buf, bus.dram_io_cas_l_buf,
          bus.dram_io_write_en_l_buf, bus.dram_io_drive_data_buf,
          bus.dram_io_drive_enable_buf} = w_cmd_q[NSTG-1];
  assign {bus.dram_io_addr_buf, bus.dram_io_bank_buf} = w_ab_q[NSTG-1];
  assign {bus.dram_io_cke_buf, bus.dram_io_clk_enable_buf, bus.dram_io_pad_enable_buf,
          bus.dram_io_pad_clk_inv_buf, bus.dram_io_channel_disabled_buf,
          bus.dram_io_ptr_clk_inv_buf} = w_misc_q[NSTG-1];
  assign bus.dram_io_data_out_buf   = w_wd_q[NSTG-1];
  assign bus.io_dram_data_valid_buf = w_vld_q[NSTG-1];
  assign {bus.io_dram_data_in_buf, bus.io_dram_ecc_in_buf} = w_rde_q[NSTG-1];
  assign bus.cmd_inflight = r_cmd_cnt;
  assign bus.rd_inflight  = r_rd_cnt;

endmodule

// File: tb/tb_dram_ddr_rptr_pipe.sv
// Scoreboard bench: three pipes (NSTG 1, 2, 4) share stimulus; expectations come from a capture history.
module tb_dram_ddr_rptr_pipe;

  typedef struct {
    logic         rst;   // rst_l was low at this edge
    logic [8:0]   cmd;   // {cs_l, ras_l, cas_l, we_l, drive_data, drive_enable} after masking
    logic [17:0]  ab;    // {addr, bank} as held by stage 0
    logic [9:0]   misc;  // {cke, clk_en, pad_en, pad_clk_inv, chan_dis, ptr_clk_inv}
    logic [287:0] wd;
    logic         vld;
    logic [287:0] rde;   // {data_in, ecc_in}
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_l;
  logic [3:0]   s_cs;
  logic         s_ras, s_cas, s_we, s_dd, s_de, s_dis;
  logic         s_cke, s_clk_en, s_pad_en, s_pad_inv;
  logic [14:0]  s_addr;
  logic [2:0]   s_bank;
  logic [4:0]   s_pci;
  logic [287:0] s_wd;
  logic         s_vld;
  logic [255:0] s_rd;
  logic [31:0]  s_ecc;

  logic [8:0]   o_cmd  [3];
  logic [17:0]  o_ab   [3];
  logic [9:0]   o_misc [3];
  logic [287:0] o_wd   [3];
  logic         o_vld  [3];
  logic [287:0] o_rde  [3];
  logic [2:0]   o_cc   [3];
  logic [2:0]   o_rc   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned N = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    dram_ddr_rptr_pipe_if #(.NSTG(N)) bus ();
    dram_ddr_rptr_pipe #(.NSTG(N)) dut (.clk(clk), .rst_l(rst_l), .bus(bus));

    assign bus.dram_io_cs_l             = s_cs;
    assign bus.dram_io_ras_l            = s_ras;
    assign bus.dram_io_cas_l            = s_cas;
    assign bus.dram_io_write_en_l       = s_we;
    assign bus.dram_io_drive_data       = s_dd;
    assign bus.dram_io_drive_enable     = s_de;
    assign bus.dram_io_channel_disabled = s_dis;
    assign bus.dram_io_cke              = s_cke;
    assign bus.dram_io_clk_enable       = s_clk_en;
    assign bus.dram_io_pad_enable       = s_pad_en;
    assign bus.dram_io_pad_clk_inv      = s_pad_inv;
    assign bus.dram_io_addr             = s_addr;
    assign bus.dram_io_bank             = s_bank;
    assign bus.dram_io_ptr_clk_inv      = s_pci;
    assign bus.dram_io_data_out         = s_wd;
    assign bus.io_dram_data_valid       = s_vld;
    assign bus.io_dram_data_in          = s_rd;
    assign bus.io_dram_ecc_in           = s_ecc;

    assign o_cmd[g]  = {bus.dram_io_cs_l_buf, bus.dram_io_ras_l_buf, bus.dram_io_cas_l_buf,
                        bus.dram_io_write_en_l_buf, bus.dram_io_drive_data_buf,
                        bus.dram_io_drive_enable_buf};
    assign o_ab[g]   = {bus.dram_io_addr_buf, bus.dram_io_bank_buf};
    assign o_misc[g] = {bus.dram_io_cke_buf, bus.dram_io_clk_enable_buf, bus.dram_io_pad_enable_buf,
                        bus.dram_io_pad_clk_inv_buf, bus.dram_io_channel_disabled_buf,
                        bus.dram_io_ptr_clk_inv_buf};
    assign o_wd[g]   = bus.dram_io_data_out_buf;
    assign o_vld[g]  = bus.io_dram_data_valid_buf;
    assign o_rde[g]  = {bus.io_dram_data_in_buf, bus.io_dram_ecc_in_buf};
    assign o_cc[g]   = 3'(bus.cmd_inflight);
    assign o_rc[g]   = 3'(bus.rd_inflight);
  end

  int   n_cmp = 0;
  int   n_bad = 0;
  ent_t sq[$];     // captures issued by the driver, consumed by the monitor
  ent_t hist[$];   // every capture, indexed by edge number
  int   last_rst = -1;
  logic have_rst = 1'b0;
  logic [17:0] m_prev_ab = '0;
  ent_t rst_e;

  function automatic int nst(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
  endfunction

  task automatic cmp(input string nm, input int g, input int t,
                     input logic [287:0] act, input logic [287:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s nstg=%0d edge=%0d got=%0h expected=%0h", nm, nst(g), t, act, exp);
    end
  endtask

  // Expected outputs after edge t: the capture NSTG-1 edges back, unless a reset came since.
  task automatic check_all(input int t);
    for (int g = 0; g < 3; g++) begin
      int n, old, lo, cc, rc;
      ent_t x;
      logic [287:0] xw, xr;
      n   = nst(g);
      old = t - n + 1;
      lo  = (old > last_rst) ? old : last_rst + 1;
      x   = (old > last_rst) ? hist[old] : rst_e;
      cc = 0;
      rc = 0;
      for (int s = lo; s <= t; s++) begin
        if (!(&hist[s].cmd[8:5])) cc++;
        if (hist[s].vld) rc++;
      end
      xw = '0;
      for (int s = old; s > last_rst; s--) begin
        if (hist[s].cmd[1]) begin xw = hist[s].wd; break; end
      end
      xr = '0;
      for (int s = old; s > last_rst; s--) begin
        if (hist[s].vld) begin xr = hist[s].rde; break; end
      end
      cmp("cmd",          g, t, 288'(o_cmd[g]),  288'(x.cmd));
      cmp("addr_bank",    g, t, 288'(o_ab[g]),   288'(x.ab));
      cmp("misc",         g, t, 288'(o_misc[g]), 288'(x.misc));
      cmp("data_out",     g, t, o_wd[g],         xw);
      cmp("rd_valid",     g, t, 288'(o_vld[g]),  288'(x.vld));
      cmp("rd_data_ecc",  g, t, o_rde[g],        xr);
      cmp("cmd_inflight", g, t, 288'(o_cc[g]),   288'(cc));
      cmp("rd_inflight",  g, t, 288'(o_rc[g]),   288'(rc));
    end
  endtask

  // Monitor: consume the capture of each edge and check all three pipes just after it.
  initial begin
    ent_t e;
    int   t;
    forever begin
      @(posedge clk);
      if (sq.size() != 0) begin
        e = sq.pop_front();
        t = hist.size();
        hist.push_back(e);
        if (e.rst) begin
          last_rst = t;
          have_rst = 1'b1;
        end
        #1;
        if (have_rst) check_all(t);
      end
    end
  end

  // Model of what stage 0 captures from the present inputs; then advance one cycle.
  task automatic step();
    ent_t e;
    e.rst  = ~rst_l;
    e.cmd  = s_dis ? 9'h1FC : {s_cs, s_ras, s_cas, s_we, s_dd, s_de};
    e.ab   = s_dis ? m_prev_ab : {s_addr, s_bank};
    e.misc = {s_cke, s_clk_en, s_pad_en, s_pad_inv, s_dis, s_pci};
    e.wd   = s_wd;
    e.vld  = s_vld;
    e.rde  = {s_rd, s_ecc};
    if (!rst_l)      m_prev_ab = '0;
    else if (!s_dis) m_prev_ab = {s_addr, s_bank};
    sq.push_back(e);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_idle();
    s_cs = 4'hF; s_ras = 1'b1; s_cas = 1'b1; s_we = 1'b1; s_dd = 1'b0; s_de = 1'b0;
    s_dis = 1'b0; s_cke = 1'b0; s_clk_en = 1'b0; s_pad_en = 1'b0; s_pad_inv = 1'b0;
    s_addr = '0; s_bank = '0; s_pci = '0; s_wd = '0; s_vld = 1'b0; s_rd = '0; s_ecc = '0;
  endtask

  task automatic set_random();
    s_cs      = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom());
    s_ras     = 1'($urandom());
    s_cas     = 1'($urandom());
    s_we      = 1'($urandom());
    s_dd      = 1'($urandom());
    s_de      = 1'($urandom());
    s_dis     = ($urandom_range(0, 7) == 0);
    s_cke     = 1'($urandom());
    s_clk_en  = 1'($urandom());
    s_pad_en  = 1'($urandom());
    s_pad_inv = 1'($urandom());
    s_addr    = 15'($urandom());
    s_bank    = 3'($urandom());
    s_pci     = 5'($urandom());
    for (int i = 0; i < 9; i++) s_wd[i*32 +: 32] = $urandom();
    s_vld     = ($urandom_range(0, 9) < 6);
    for (int i = 0; i < 8; i++) s_rd[i*32 +: 32] = $urandom();
    s_ecc     = $urandom();
    rst_l     = ($urandom_range(0, 99) != 0);
  endtask

  initial begin
    rst_e.rst = 1'b0; rst_e.cmd = 9'h1FC; rst_e.ab = '0; rst_e.misc = 10'h020;
    rst_e.wd = '0; rst_e.vld = 1'b0; rst_e.rde = '0;

    set_idle();
    rst_l = 1'b0;
    steps(3);
    rst_l = 1'b1;
    steps(2);

    // Single command, then idle.
    s_cs = 4'b1110; s_addr = 15'h1A5; s_ras = 1'b0;
    step();
    set_idle();
    steps(6);

    // Command in the same cycle the channel is disabled.
    s_dis = 1'b1; s_cs = 4'b0111; s_ras = 1'b0; s_cas = 1'b0; s_we = 1'b0; s_dd = 1'b1;
    s_addr = 15'h7FF; s_wd = 288'hDEAD;
    step();
    s_cs = 4'b0000;
    steps(2);
    set_idle();
    steps(6);

    // Eight back-to-back read beats.
    for (int i = 0; i < 8; i++) begin
      s_vld = 1'b1; s_rd = 256'(i); s_ecc = 32'(i + 100);
      step();
    end
    set_idle();
    steps(6);

    // Valid beat followed by an invalid cycle carrying different data.
    s_vld = 1'b1; s_rd = 256'hAA;
    step();
    s_vld = 1'b0; s_rd = 256'h55;
    steps(3);
    set_idle();
    steps(5);

    // Write data with and without drive_data.
    s_cs = 4'b1011; s_dd = 1'b1; s_wd = 288'h1234;
    step();
    s_dd = 1'b0; s_wd = 288'hFFFF;
    steps(3);
    set_idle();
    steps(5);

    // Reset while commands and beats are in flight.
    for (int i = 0; i < 2; i++) begin
      s_cs = 4'b1101; s_addr = 15'(i + 1); s_dd = 1'b1; s_wd = 288'(i + 7);
      s_vld = 1'b1; s_rd = 256'(i + 16);
      step();
    end
    rst_l = 1'b0;
    step();
    rst_l = 1'b1;
    set_idle();
    steps(6);

    // Randomized traffic with occasional disable and reset.
    for (int i = 0; i < 1500; i++) begin
      set_random();
      step();
    end
    rst_l = 1'b1;
    set_idle();
    steps(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
